// File: rtl/alu_cpu_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : alu_cpu_sequencer_if
//  Purpose  : Instruction bus between the sequencer (master) and the
//             accumulator ALU CPU (slave).
//  Revision : 1.0  initial release
// ============================================================================
interface alu_cpu_sequencer_if;
   logic [2:0]  cpu_instruction;
   logic [15:0] cpu_data;
   logic        cpu_new_instruction;
   logic        cpu_ready;
   logic [15:0] cpu_result;

   modport master (
      output cpu_instruction,
      output cpu_data,
      output cpu_new_instruction,
      input  cpu_ready,
      input  cpu_result
   );

   modport slave (
      input  cpu_instruction,
      input  cpu_data,
      input  cpu_new_instruction,
      output cpu_ready,
      output cpu_result
   );
endinterface
`default_nettype wire

// File: rtl/alu_cpu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : alu_cpu_sequencer
//  Purpose  : Stores a short {opcode, operand} program and replays it into
//             the accumulator ALU CPU, pacing each issue on cpu_ready and
//             capturing DataOutput after each instruction completes.
//  Options  : SEQ_TIMEOUT_EN - bound every ready wait by TIMEOUT cycles and
//             flag a sticky error when it expires.
//  Revision : 1.0  initial release
// ============================================================================
module alu_cpu_sequencer #(
   parameter int AW      = 4,
   parameter int TIMEOUT = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 prog_we,
   input  logic [AW-1:0]        prog_addr,
   input  logic [18:0]          prog_wdata,
   input  logic [AW:0]          prog_len,
   input  logic                 start,
   output logic                 busy,
   output logic                 done,
   output logic                 error,
   alu_cpu_sequencer_if.master  cpu_if,
   output logic [15:0]          result,
   output logic                 result_valid,
   output logic [AW-1:0]        result_index
);

   localparam int c_DEPTH = 2 ** AW;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_FETCH     = 3'd1,
      S_ISSUE     = 3'd2,
      S_WAIT_ACK  = 3'd3,
      S_WAIT_DONE = 3'd4,
      S_CAPTURE   = 3'd5,
      S_FIN       = 3'd6
   } state_t;

   state_t        r_state;
   logic [AW:0]   r_len;
   logic [AW-1:0] r_pc;
   logic [18:0]   r_word;
   logic [18:0]   r_mem [c_DEPTH];

   // A zero timeout would make every wait fail before ready is ever seen.
   if (TIMEOUT < 1) begin : g_bad_timeout
      $error("alu_cpu_sequencer: TIMEOUT must be at least 1");
   end

`ifdef SEQ_TIMEOUT_EN
   localparam int c_TW = $clog2(TIMEOUT + 1);
   localparam logic [c_TW-1:0] c_TMO_LAST = c_TW'(TIMEOUT - 1);
   logic [c_TW-1:0] r_tmo;
`endif

   // Program memory: writes only while idle so a running program is never
   // modified underneath the replay.
   always_ff @(posedge clk) begin
      if (prog_we && (r_state == S_IDLE)) begin
         r_mem[prog_addr] <= prog_wdata;
      end
   end

   // Sequencer FSM with registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state                    <= S_IDLE;
         r_len                      <= '0;
         r_pc                       <= '0;
         r_word                     <= '0;
         busy                       <= 1'b0;
         done                       <= 1'b0;
         error                      <= 1'b0;
         result                     <= '0;
         result_valid               <= 1'b0;
         result_index               <= '0;
         cpu_if.cpu_instruction     <= '0;
         cpu_if.cpu_data            <= '0;
         cpu_if.cpu_new_instruction <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
         r_tmo                      <= '0;
`endif
      end else begin
         done                       <= 1'b0;
         result_valid               <= 1'b0;
         cpu_if.cpu_new_instruction <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_len   <= prog_len;
                  r_pc    <= '0;
                  error   <= 1'b0;
                  busy    <= 1'b1;
                  r_state <= (prog_len == '0) ? S_FIN : S_FETCH;
               end
            end
            S_FETCH: begin
               r_word  <= r_mem[r_pc];
               r_state <= S_ISSUE;
`ifdef SEQ_TIMEOUT_EN
               r_tmo   <= '0;
`endif
            end
            S_ISSUE: begin
               if (cpu_if.cpu_ready) begin
                  cpu_if.cpu_instruction     <= r_word[18:16];
                  cpu_if.cpu_data            <= r_word[15:0];
                  cpu_if.cpu_new_instruction <= 1'b1;
                  r_state                    <= S_WAIT_ACK;
`ifdef SEQ_TIMEOUT_EN
                  r_tmo                      <= '0;
               end else if (r_tmo == c_TMO_LAST) begin
                  error   <= 1'b1;
                  r_state <= S_FIN;
               end else begin
                  r_tmo   <= r_tmo + 1'b1;
`endif
               end
            end
            S_WAIT_ACK: begin
               // Ready falling is the CPU's acknowledgement of the issue.
               if (!cpu_if.cpu_ready) begin
                  r_state <= S_WAIT_DONE;
`ifdef SEQ_TIMEOUT_EN
                  r_tmo   <= '0;
               end else if (r_tmo == c_TMO_LAST) begin
                  error                      <= 1'b1;
                  cpu_if.cpu_new_instruction <= 1'b0;
                  r_state                    <= S_FIN;
               end else begin
                  r_tmo   <= r_tmo + 1'b1;
`endif
               end
            end
            S_WAIT_DONE: begin
               if (cpu_if.cpu_ready) begin
                  r_state <= S_CAPTURE;
`ifdef SEQ_TIMEOUT_EN
               end else if (r_tmo == c_TMO_LAST) begin
                  error   <= 1'b1;
                  r_state <= S_FIN;
               end else begin
                  r_tmo   <= r_tmo + 1'b1;
`endif
               end
            end
            S_CAPTURE: begin
               result       <= cpu_if.cpu_result;
               result_index <= r_pc;
               result_valid <= 1'b1;
               // pc stops at len-1; it never wraps even at full depth.
               if ({1'b0, r_pc} == (r_len - 1'b1)) begin
                  r_state <= S_FIN;
               end else begin
                  r_pc    <= r_pc + 1'b1;
                  r_state <= S_FETCH;
               end
            end
            S_FIN: begin
               done    <= 1'b1;
               busy    <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_alu_cpu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_cpu_sequencer
//  Purpose  : Directed, table-driven bench for alu_cpu_sequencer with a
//             simple behavioural CPU model on the instruction bus.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_cpu_sequencer;

   localparam int c_AW = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              prog_we = 1'b0;
   logic [c_AW-1:0]   prog_addr = '0;
   logic [18:0]       prog_wdata = '0;
   logic [c_AW:0]     prog_len = '0;
   logic              start = 1'b0;
   logic              busy, done, error, result_valid;
   logic [15:0]       result;
   logic [c_AW-1:0]   result_index;

   alu_cpu_sequencer_if bus ();

   alu_cpu_sequencer #(.AW(c_AW), .TIMEOUT(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .prog_we      (prog_we),
      .prog_addr    (prog_addr),
      .prog_wdata   (prog_wdata),
      .prog_len     (prog_len),
      .start        (start),
      .busy         (busy),
      .done         (done),
      .error        (error),
      .cpu_if       (bus),
      .result       (result),
      .result_valid (result_valid),
      .result_index (result_index)
   );

   always #5 clk = ~clk;

   // ---------------- CPU model ----------------
   logic        m_ready = 1'b1;
   logic [15:0] m_result = '0;
   logic        hold_low = 1'b0;
   logic        never_done = 1'b0;
   logic        fixed_en = 1'b0;
   logic [15:0] fixed_val = '0;
   int          busy_low = 1;
   bit          m_busy = 0;
   int          m_left = 0;
   logic [2:0]  m_op;
   logic [15:0] m_data;
   int          stab_err = 0;

   assign bus.cpu_ready  = m_ready & ~hold_low;
   assign bus.cpu_result = m_result;

   // Model drops ready when it sees an issue, holds it low busy_low cycles,
   // then raises it with the result (~data unless a fixed value is forced).
   always @(negedge clk) begin
      if (!rst) begin
         m_busy  = 0;
         m_ready = 1'b1;
      end else if (m_busy) begin
         if (bus.cpu_instruction !== m_op || bus.cpu_data !== m_data || bus.cpu_new_instruction)
            stab_err++;
         if (m_left > 0) m_left--;
         if (m_left == 0 && !never_done) begin
            m_busy   = 0;
            m_ready  = 1'b1;
            m_result = fixed_en ? fixed_val : ~m_data;
         end
      end else if (bus.cpu_new_instruction) begin
         m_busy   = 1;
         m_op     = bus.cpu_instruction;
         m_data   = bus.cpu_data;
         m_ready  = 1'b0;
         m_result = 16'hDEAD;
         m_left   = busy_low;
      end
   end

   // ---------------- Monitor ----------------
   int          cyc = 0;
   int          done_cnt = 0;
   int          busy_cyc = 0;
   int          first_iss_cyc = -1;
   int          done_cyc = -1;
   logic [2:0]  iss_op[$];
   logic [15:0] iss_data[$];
   logic [15:0] res_val[$];
   logic [3:0]  res_idx[$];

   always @(negedge clk) begin
      cyc++;
      if (bus.cpu_new_instruction) begin
         if (iss_op.size() == 0) first_iss_cyc = cyc;
         iss_op.push_back(bus.cpu_instruction);
         iss_data.push_back(bus.cpu_data);
      end
      if (result_valid) begin
         res_val.push_back(result);
         res_idx.push_back(result_index);
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (busy) busy_cyc++;
   end

   // ---------------- Checking helpers ----------------
   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic load(input logic [c_AW-1:0] a, input logic [18:0] w);
      prog_we = 1'b1; prog_addr = a; prog_wdata = w;
      tick();
      prog_we = 1'b0;
   endtask

   task automatic clear_logs();
      iss_op.delete(); iss_data.delete(); res_val.delete(); res_idx.delete();
      done_cnt = 0; busy_cyc = 0; first_iss_cyc = -1; done_cyc = -1; stab_err = 0;
   endtask

   task automatic start_run(input logic [c_AW:0] len);
      prog_len = len; start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input string name, input int budget);
      int n;
      n = 0;
      while (done_cnt == 0 && n < budget) begin
         tick();
         n++;
      end
      if (done_cnt == 0) chk({name, "_timeout"}, 32'd0, 32'd1);
   endtask

   // ---------------- Vector table ----------------
   typedef struct {
      logic [2:0]  op;
      logic [15:0] operand;
      logic [15:0] exp_res;
   } vec_t;

   vec_t tbl[8];

   initial begin
      tbl[0] = '{3'd0, 16'h0000, 16'hFFFF};
      tbl[1] = '{3'd1, 16'h00A5, 16'hFF5A};
      tbl[2] = '{3'd2, 16'h1234, 16'hEDCB};
      tbl[3] = '{3'd3, 16'hFFFF, 16'h0000};
      tbl[4] = '{3'd4, 16'h8000, 16'h7FFF};
      tbl[5] = '{3'd5, 16'h0F0F, 16'hF0F0};
      tbl[6] = '{3'd6, 16'h5555, 16'hAAAA};
      tbl[7] = '{3'd7, 16'hC3A1, 16'h3C5E};

      // ---- reset state ----
      tick(); tick();
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_error", error, 0);
      chk("rst_new_instr", bus.cpu_new_instruction, 0);
      chk("rst_instr", bus.cpu_instruction, 0);
      chk("rst_data", bus.cpu_data, 0);
      chk("rst_result", result, 0);
      chk("rst_result_valid", result_valid, 0);
      chk("rst_result_index", result_index, 0);
      rst = 1'b1;
      tick();

      // ---- single instruction, fixed CPU result ----
      load(4'd0, {3'd1, 16'h00A5});
      clear_logs();
      fixed_en = 1'b1; fixed_val = 16'h1234; busy_low = 3;
      start_run(5'd1);
      wait_done("single", 40);
      tick(); tick();
      chk("single_issues", iss_op.size(), 1);
      if (iss_op.size() == 1) begin
         chk("single_op", iss_op[0], 3'd1);
         chk("single_data", iss_data[0], 16'h00A5);
      end
      chk("single_results", res_val.size(), 1);
      if (res_val.size() == 1) begin
         chk("single_result", res_val[0], 16'h1234);
         chk("single_index", res_idx[0], 0);
      end
      chk("single_done_cnt", done_cnt, 1);
      chk("single_busy", busy, 0);
      chk("single_error", error, 0);
      fixed_en = 1'b0;

      // ---- full-depth table run, fast CPU ----
      for (int i = 0; i < 16; i++) load(4'(i), {tbl[i % 8].op, tbl[i % 8].operand});
      clear_logs();
      busy_low = 1;
      start_run(5'd16);
      wait_done("full", 300);
      tick(); tick();
      chk("full_issues", iss_op.size(), 16);
      chk("full_results", res_val.size(), 16);
      for (int k = 0; k < 16; k++) begin
         if (k < iss_op.size()) begin
            chk("full_op", iss_op[k], tbl[k % 8].op);
            chk("full_data", iss_data[k], tbl[k % 8].operand);
         end
         if (k < res_val.size()) begin
            chk("full_result", res_val[k], tbl[k % 8].exp_res);
            chk("full_index", res_idx[k], k);
         end
      end
      chk("full_done_cnt", done_cnt, 1);
      chk("full_stable", stab_err, 0);

      // ---- prog_len = 0 ----
      clear_logs();
      start_run(5'd0);
      wait_done("len0", 2);
      tick();
      chk("len0_done_cnt", done_cnt, 1);
      chk("len0_issues", iss_op.size(), 0);
      chk("len0_busy_le1", (busy_cyc <= 1), 1);

      // ---- 3 words, slow CPU; restart and write attempts while busy ----
      clear_logs();
      busy_low = 5;
      start_run(5'd3);
      tick(); tick();
      start = 1'b1; prog_len = 5'd1;
      prog_we = 1'b1; prog_addr = 4'd1; prog_wdata = 19'h7FFFF;
      tick();
      start = 1'b0; prog_we = 1'b0;
      wait_done("slow3", 100);
      for (int i = 0; i < 6; i++) tick();
      chk("slow3_issues", iss_op.size(), 3);
      chk("slow3_results", res_val.size(), 3);
      for (int k = 0; k < 3; k++) begin
         if (k < iss_data.size()) chk("slow3_data", iss_data[k], tbl[k].operand);
         if (k < res_idx.size()) chk("slow3_index", res_idx[k], k);
      end
      chk("slow3_done_cnt", done_cnt, 1);
      chk("slow3_error", error, 0);
      chk("slow3_stable", stab_err, 0);

      // readback: addr1 must still hold its original word
      clear_logs();
      busy_low = 1;
      start_run(5'd2);
      wait_done("readback", 60);
      tick();
      chk("readback_issues", iss_op.size(), 2);
      if (iss_op.size() == 2) begin
         chk("readback_op", iss_op[1], tbl[1].op);
         chk("readback_data", iss_data[1], tbl[1].operand);
      end

      // ---- cpu_ready low at start ----
      clear_logs();
      hold_low = 1'b1;
      start_run(5'd1);
      for (int i = 0; i < 6; i++) tick();
      chk("stall_no_issue", iss_op.size(), 0);
      begin
         int rel_cyc;
         rel_cyc = cyc;
         hold_low = 1'b0;
         wait_done("stall", 40);
         chk("stall_issue_cycle", first_iss_cyc, rel_cyc + 1);
         chk("stall_results", res_val.size(), 1);
      end

      // ---- asynchronous reset in WAIT_DONE ----
      tick();
      clear_logs();
      busy_low = 8;
      start_run(5'd1);
      for (int i = 0; i < 4; i++) tick();
      chk("midrst_in_run", busy, 1);
      #2 rst = 1'b0;
      #1;
      chk("midrst_new_instr", bus.cpu_new_instruction, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_result", result, 0);
      tick(); tick();
      rst = 1'b1;
      tick();
      clear_logs();
      busy_low = 2;
      start_run(5'd1);
      wait_done("after_rst", 40);
      tick();
      chk("after_rst_results", res_val.size(), 1);
      if (res_val.size() == 1) chk("after_rst_result", res_val[0], tbl[0].exp_res);

`ifdef SEQ_TIMEOUT_EN
      // ---- timeout in WAIT_DONE ----
      clear_logs();
      busy_low = 1; never_done = 1'b1;
      start_run(5'd2);
      wait_done("tmo", 60);
      tick();
      chk("tmo_error", error, 1);
      chk("tmo_results", res_val.size(), 0);
      chk("tmo_issues", iss_op.size(), 1);
      chk("tmo_done_delay", done_cyc - first_iss_cyc, 10);
      never_done = 1'b0;
      tick(); tick(); tick();
      clear_logs();
      start_run(5'd1);
      chk("tmo_error_cleared", error, 0);
      wait_done("tmo_recover", 40);
      tick();
      chk("tmo_recover_results", res_val.size(), 1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/alu_cpu_sequencer.md
Name: alu_cpu_sequencer

Overview:
Instruction-issuing master for the accumulator ALU CPU. It stores a short program of {opcode, operand} words and replays it into the CPU's instruction/new_instruction/DataInput inputs. It paces each issue on the CPU's ready output and captures DataOutput after each instruction completes. It sits beside the CPU in the test/top wrapper and replaces hand-driven stimulus.

Parameters:
AW, 4, program address width; program memory depth = 2**AW words
TIMEOUT, 64, max cycles to wait for each ready edge (used only with SEQ_TIMEOUT_EN)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
prog_we  input  1  program write strobe
prog_addr  input  AW  program write address
prog_wdata  input  19  program word: [18:16] opcode, [15:0] operand
prog_len  input  AW+1  number of words to run, 0..2**AW; sampled on start
start  input  1  one-cycle run request
busy  output  1  run in progress
done  output  1  one-cycle pulse at end of run (normal or error)
error  output  1  sticky; set on timeout, cleared on next accepted start
cpu_instruction  output  3  to CPU instruction
cpu_data  output  16  to CPU DataInput
cpu_new_instruction  output  1  to CPU new_instruction
cpu_ready  input  1  from CPU ready
cpu_result  input  16  from CPU DataOutput
result  output  16  last captured cpu_result
result_valid  output  1  one-cycle pulse when result updates
result_index  output  AW  program address of the instruction that produced result

Behaviour:
- Reset (rst=0, asynchronous): state IDLE. All outputs are 0: busy, done, error, cpu_new_instruction, cpu_instruction, cpu_data, result, result_valid, result_index. Program memory contents are not reset. If reset is asserted mid-run, cpu_new_instruction drops immediately and the run is abandoned.
- All outputs are registered. Program memory is written synchronously and read synchronously (1-cycle read).
- prog_we is accepted only in IDLE and is silently dropped while busy=1.
- start is accepted only in IDLE; it is ignored while busy. An accepted start latches prog_len, clears pc and clears error.
- FSM states:
  - IDLE: on start with prog_len=0, go to FIN. On start with prog_len>0, go to FETCH and set busy=1 on the next cycle.
  - FETCH: read mem[pc]; go to ISSUE.
  - ISSUE: wait for cpu_ready=1. On the cycle cpu_ready=1, drive cpu_instruction/cpu_data from the fetched word and assert cpu_new_instruction for exactly one cycle. Go to WAIT_ACK.
  - WAIT_ACK: wait for cpu_ready=0, meaning the CPU has accepted the instruction. Then go to WAIT_DONE.
  - WAIT_DONE: wait for cpu_ready=1. Then go to CAPTURE.
  - CAPTURE: result<=cpu_result, result_index<=pc, result_valid pulses. If pc==len-1, go to FIN; otherwise pc<=pc+1 and go to FETCH.
  - FIN: done pulses for 1 cycle, busy<=0, go to IDLE.
- cpu_instruction and cpu_data hold their values from ISSUE until the next ISSUE. They are never changed while the CPU is processing.
- Minimum latency per instruction: FETCH(1) + ISSUE(1) + WAIT_ACK(>=1) + WAIT_DONE(>=1) + CAPTURE(1) = 5 cycles.
- Opcodes are passed through opaque; the sequencer does not decode them.
- prog_len=2**AW runs every word. pc stops at len-1 and does not wrap.
- When cpu_ready=0 on entering ISSUE, the sequencer stalls without issuing.

Optional Feature:
SEQ_TIMEOUT_EN
- Defined: a counter restarts on entry to ISSUE, WAIT_ACK and WAIT_DONE. If TIMEOUT cycles pass in any of these states without the awaited ready level, the sequencer sets error=1, forces cpu_new_instruction=0 and goes to FIN (done pulses, no result_valid for that instruction).
- Undefined: the sequencer waits indefinitely and error is tied to 0.

Test Plan:
- Reset mid-run: assert rst=0 while in WAIT_DONE -> cpu_new_instruction, busy and result are 0 in the same cycle; a following start with prog_len=1 runs normally.
- Single instruction: load addr0={3'd1,16'h00A5}, prog_len=1, start; CPU model drops ready 1 cycle after issue, raises it 3 cycles later with cpu_result=16'h1234 -> exactly one new_instruction pulse with instruction=1, data=00A5; result=1234, result_index=0, one result_valid, done pulse, busy=0.
- Program of 3 words, slow CPU (ready low 5 cycles each) -> 3 issue pulses in address order, 3 result_valid pulses with indices 0,1,2, one done pulse, error=0.
- prog_len=0 -> done pulses within 2 cycles of start; no cpu_new_instruction; busy rises at most 1 cycle. A second start while busy is ignored, and prog_we while busy does not alter memory (verified by readback run).
- cpu_ready=0 at start -> no issue until ready rises; the issue occurs on the first ready-high cycle.
- SEQ_TIMEOUT_EN, TIMEOUT=8: CPU never raises ready after ack -> error=1 and done pulse 8 cycles after entering WAIT_DONE; no result_valid; the next start clears error.
